// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
// Single-outstanding AXI4-Lite master that turns the CPU core's simple
// request/response port into AXI4-Lite read and write transactions.
//
// Handshake rule, used on every channel on both sides:
//   - A transfer happens on the rising clock edge where valid and ready are both 1.
//   - Once a valid is raised, it and its payload stay stable until that edge.
//   - Every valid or ready this block drives is decoded from registered state only.
//     None of them depends combinationally on an input.
//   - The CPU port works the same way: a request is taken on the edge where
//     req_valid && req_ready.
//
// Optional feature: define AXI_TIMEOUT_EN to add a watchdog.
//   - The watchdog aborts a transaction that sits in a bus wait state for TIMEOUT cycles.
//   - It reports the abort as an error completion.
//   - The bridge then parks in HUNG until reset.
//
// The FSM state is visible as state_q for checker binding.
module axi_lite_master_bridge #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [2:0] PROT    = 3'b000,
  parameter int         TIMEOUT = 1023,
  localparam int        STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU request / response port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              axi_error,
  // AXI4-Lite write address channel
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [2:0]        axi_awprot,
  // AXI4-Lite write data channel
  output logic [DATA_W-1:0] axi_wdata,
  output logic [STRB_W-1:0] axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [2:0]        axi_arprot,
  // AXI4-Lite read data channel
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  // Only 32- and 64-bit buses are supported, and the watchdog needs a positive limit.
  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT < 1) begin : g_bad_params
    $error("axi_lite_master_bridge: DATA_W must be 32 or 64 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
`ifdef AXI_TIMEOUT_EN
    , HUNG
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              axi_error_q;
  logic              aw_done_q, w_done_q;
  logic              aw_hs, w_hs;
  logic              rresp_err, bresp_err;
  logic              bus_en;

  // Handshake strobes and error decode.
  // SLVERR (10) and DECERR (11) are failures; OKAY and EXOKAY are success.
  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign rresp_err = (axi_rresp == 2'b10) || (axi_rresp == 2'b11);
  assign bresp_err = (axi_bresp == 2'b10) || (axi_bresp == 2'b11);

`ifdef AXI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            to_q;
  logic            wait_st;
  logic            timeout_hit;

  assign wait_st = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                   (state_q == WR_REQ)  || (state_q == WR_RESP);
  assign bus_en  = (state_q != HUNG);
`else
  assign bus_en  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A watchdog expiry overrides "no progress this cycle" only.
  always_comb begin
    state_d = state_q;
`ifdef AXI_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE:    if (req_valid) state_d = req_we ? WR_REQ : RD_ADDR;
      RD_ADDR: if (axi_arready) state_d = RD_DATA;
      RD_DATA: if (axi_rvalid) state_d = DONE;
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (axi_bvalid) state_d = DONE;
`ifdef AXI_TIMEOUT_EN
      DONE:    state_d = to_q ? HUNG : IDLE;
      HUNG:    state_d = HUNG;
`else
      DONE:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
`ifdef AXI_TIMEOUT_EN
    if (wait_st && (state_d == state_q) && (wd_cnt_q == WD_W'(TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
      state_d     = DONE;
    end
`endif
  end

  // Request latch, response capture, write-channel completion flags and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      axi_error_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == RD_DATA && axi_rvalid) begin
        rdata_q <= rresp_err ? '0 : axi_rdata;
        err_q   <= rresp_err;
      end
      if (state_q == WR_RESP && axi_bvalid) begin
        err_q <= bresp_err;
      end
`ifdef AXI_TIMEOUT_EN
      if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
`endif
      if (state_q == DONE && err_q) begin
        axi_error_q <= 1'b1;
      end
      // Each flag remembers its own handshake while both channels are still open.
      // Both flags clear whenever WR_REQ is left.
      if (state_q == WR_REQ && state_d == WR_REQ) begin
        aw_done_q <= aw_done_q | aw_hs;
        w_done_q  <= w_done_q | w_hs;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

`ifdef AXI_TIMEOUT_EN
  // Watchdog: restarts on every state change, counts while waiting on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state_d != state_q) wd_cnt_q <= '0;
      else if (wait_st)       wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (state_q == IDLE && req_valid) to_q <= 1'b0;
      if (timeout_hit)                  to_q <= 1'b1;
    end
  end
`endif

  // Port decode: every valid and ready is a function of registered state only.
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_rdata  = resp_valid ? rdata_q : '0;
  assign resp_err    = resp_valid && err_q;
  assign axi_error   = axi_error_q;

  assign axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi_bready  = (state_q == WR_RESP);
  assign axi_arvalid = (state_q == RD_ADDR);
  assign axi_rready  = (state_q == RD_DATA);

  assign axi_awaddr  = bus_en ? addr_q  : '0;
  assign axi_araddr  = bus_en ? addr_q  : '0;
  assign axi_wdata   = bus_en ? wdata_q : '0;
  assign axi_wstrb   = bus_en ? wstrb_q : '0;
  assign axi_awprot  = bus_en ? PROT    : 3'b000;
  assign axi_arprot  = bus_en ? PROT    : 3'b000;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Testbench for axi_lite_master_bridge.
// It runs a table of directed transactions against an inline AXI4-Lite slave.
// That slave has per-channel ready delays and an optional early-valid mode.
// Hand-written sequences follow the table:
//   - reset in mid-transaction;
//   - the watchdog, when AXI_TIMEOUT_EN is defined.
module tb_axi_lite_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_we = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic          req_ready, resp_valid, resp_err, axi_error;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic          axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
  logic [2:0]    axi_awprot, axi_arprot;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_awready = 0, axi_wready = 0, axi_bvalid = 0, axi_arready = 0, axi_rvalid = 0;
  logic [1:0]    axi_bresp = '0, axi_rresp = '0;
  logic [DW-1:0] axi_rdata = '0;

  axi_lite_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .PROT(3'b000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .axi_error(axi_error),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic          hold;    // keep req_valid high across the whole transaction
    logic          early;   // slave raises bvalid/rvalid before bready/rready
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] sdata;   // slave read data
    logic [1:0]    resp;    // slave bresp/rresp
    int            aw_dly, w_dly, ar_dly, r_dly;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat; // cycles from acceptance to resp_valid
    logic          exp_axerr;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver / slave ----------------
  // Call at a falling edge while the bridge is idle; returns at the falling edge after the response.
  task automatic run_txn(input vec_t v, input int idx);
    int cyc = 0, resp_cyc = -1;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit aw_seen = 0, ar_seen = 0, r_done = 0, b_done = 0;
    bit stable_ok = 1, busy_ok = 1, got = 0;
    logic [DW-1:0] got_rdata = '0;
    logic [DW-1:0] exp_rdata;
    logic          got_err = 0;

    chk($sformatf("v%0d_req_ready_idle", idx), 64'(req_ready), 64'd1);
    exp_q.push_back(v.exp_rdata);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;

    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!v.hold) begin
        // Scramble the request port so only latched values can reach the bus.
        req_valid = 0; req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wdata; req_wstrb = ~v.wstrb;
      end
      if (req_ready) busy_ok = 0;

      if (axi_awvalid) begin
        aw_seen = 1;
        if (axi_awaddr !== v.addr || axi_awprot !== 3'b000) stable_ok = 0;
        axi_awready = (aw_cnt >= v.aw_dly); aw_cnt++;
        if (axi_awready) aw_hs++;
      end else axi_awready = 0;

      if (axi_wvalid) begin
        if (axi_wdata !== v.wdata || axi_wstrb !== v.wstrb) stable_ok = 0;
        axi_wready = (w_cnt >= v.w_dly); w_cnt++;
        if (axi_wready) w_hs++;
      end else axi_wready = 0;

      if (axi_arvalid) begin
        ar_seen = 1;
        if (axi_araddr !== v.addr || axi_arprot !== 3'b000) stable_ok = 0;
        axi_arready = (ar_cnt >= v.ar_dly); ar_cnt++;
        if (axi_arready) ar_hs++;
      end else axi_arready = 0;

      axi_rvalid = (axi_rready && r_cnt >= v.r_dly) || (v.early && ar_seen && !r_done);
      if (axi_rready) r_cnt++;
      axi_rdata = axi_rvalid ? v.sdata : 32'hBAD0_BAD0;
      axi_rresp = axi_rvalid ? v.resp : 2'b11;
      if (axi_rvalid && axi_rready) begin r_hs++; r_done = 1; end

      axi_bvalid = axi_bready || (v.early && aw_seen && !b_done);
      axi_bresp  = axi_bvalid ? v.resp : 2'b11;
      if (axi_bvalid && axi_bready) begin b_hs++; b_done = 1; end

      if (resp_valid) begin
        got = 1; resp_cyc = cyc; got_rdata = resp_rdata; got_err = resp_err;
      end
    end
    axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_rvalid = 0; axi_bvalid = 0;

    exp_rdata = exp_q.pop_front();
    if (!got) begin
      chk($sformatf("v%0d_resp_timeout", idx), 64'd0, 64'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), 64'(resp_cyc), 64'(v.exp_lat));
      chk($sformatf("v%0d_rdata", idx), 64'(got_rdata), 64'(exp_rdata));
      chk($sformatf("v%0d_err", idx), 64'(got_err), 64'(v.exp_err));
      chk($sformatf("v%0d_payload_stable", idx), 64'(stable_ok), 64'd1);
      chk($sformatf("v%0d_busy_no_ready", idx), 64'(busy_ok), 64'd1);
      chk($sformatf("v%0d_wr_handshakes", idx), 64'(aw_hs * 100 + w_hs * 10 + b_hs),
          v.we ? 64'd111 : 64'd0);
      chk($sformatf("v%0d_rd_handshakes", idx), 64'(ar_hs * 10 + r_hs), v.we ? 64'd0 : 64'd11);
    end
    @(negedge clk);
    chk($sformatf("v%0d_resp_single_pulse", idx), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d_ready_after", idx), 64'(req_ready), 64'd1);
    chk($sformatf("v%0d_axi_error", idx), 64'(axi_error), 64'(v.exp_axerr));
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   cnt;
    bit   got;
    bit   hung_ok;

    //          we hold early addr          wdata          strb     sdata          resp   aw w ar r  exp_rdata      err lat axerr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'hDEADBEEF, 2'b00, 0,0,0,0, 32'hDEADBEEF, 1'b0, 3, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h12345678, 4'b0011, 32'h0,         2'b00, 3,0,0,0, 32'h0,        1'b0, 6, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h0,         4'b0000, 32'hA5A55A5A, 2'b01, 0,0,2,1, 32'hA5A55A5A, 1'b0, 6, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_400C, 32'hCAFEF00D, 4'b1111, 32'h0,         2'b01, 1,2,0,0, 32'h0,        1'b0, 5, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0BADC0DE, 4'b1000, 32'h0,         2'b00, 0,0,0,0, 32'h0,        1'b0, 3, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_5004, 32'h87654321, 4'b0100, 32'h0,         2'b00, 2,2,0,0, 32'h0,        1'b0, 5, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_6000, 32'h0,         4'b0000, 32'h13579BDF, 2'b00, 0,0,1,0, 32'h13579BDF, 1'b0, 4, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'hFFFF0000, 2'b10, 0,0,0,0, 32'h0,        1'b1, 3, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_1004, 32'h0,         4'b0000, 32'h11223344, 2'b00, 0,0,0,0, 32'h11223344, 1'b0, 3, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'hFEEDFACE, 4'b1111, 32'h0,         2'b11, 0,0,0,0, 32'h0,        1'b1, 3, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_7004, 32'h0,         4'b0000, 32'h55AA55AA, 2'b11, 0,0,0,0, 32'h0,        1'b1, 3, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_axi_valids", 64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}), 64'd0);
    chk("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    chk("rst_axi_error", 64'(axi_error), 64'd0);

    // Table-driven transactions.
    for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

    // Reset asserted while in WR_REQ: valids drop without a clock edge.
    req_valid = 1; req_we = 1; req_addr = 32'h0000_8000; req_wdata = 32'h0F0F0F0F; req_wstrb = 4'b1111;
    @(negedge clk);
    req_valid = 0;
    chk("midrst_pre_valids", 64'({axi_awvalid, axi_wvalid, req_ready}), 64'b110);
    #2 rst_n = 0;
    #1;
    chk("midrst_async_valids", 64'({axi_awvalid, axi_wvalid}), 64'd0);
    chk("midrst_async_ready", 64'(req_ready), 64'd1);
    chk("midrst_async_error", 64'(axi_error), 64'd0);
    @(negedge clk);
    rst_n = 1;
    v = '{1'b0, 1'b0, 1'b0, 32'h0000_9000, 32'h0, 4'b0000, 32'h2468ACE0, 2'b00, 0,0,0,0,
          32'h2468ACE0, 1'b0, 3, 1'b0};
    run_txn(v, 100);

`ifdef AXI_TIMEOUT_EN
    // Watchdog: arready never comes, response must follow arvalid by TIMEOUT cycles.
    req_valid = 1; req_we = 0; req_addr = 32'h0000_A000;
    @(negedge clk);
    req_valid = 0;
    chk("to_arvalid_rise", 64'(axi_arvalid), 64'd1);
    cnt = 0; got = 0;
    while (!got && cnt < 100) begin
      if (resp_valid) got = 1;
      else begin @(negedge clk); cnt++; end
    end
    chk("to_latency", 64'(cnt), 64'd16);
    chk("to_resp", 64'({resp_valid, resp_err, resp_rdata}), {31'd0, 1'b1, 1'b1, 32'h0});
    hung_ok = 1;
    req_valid = 1;
    repeat (20) begin
      @(negedge clk);
      if (req_ready || axi_arvalid || axi_awvalid || axi_wvalid || axi_rready || axi_bready ||
          resp_valid) hung_ok = 0;
    end
    req_valid = 0;
    chk("to_hung_quiet", 64'(hung_ok), 64'd1);
    chk("to_axi_error", 64'(axi_error), 64'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("to_recover_ready", 64'(req_ready), 64'd1);
    chk("to_recover_error", 64'(axi_error), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Parametrised single-outstanding AXI4-Lite master that converts the CPU core's simple request/response memory port into AXI4-Lite read and write transactions. It replaces the fixed 32-bit CPU-to-AXI wrapper and sits between the pipelined core's load/store/fetch arbiter and the system interconnect. It adds configurable widths, per-transaction error reporting, a sticky error flag and an optional watchdog timeout.

## Interface
- ADDR_W, 32, address width of request port and AXI AR/AW.
- DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.
- PROT, 3'b000, constant driven on axi_awprot and axi_arprot.
- TIMEOUT, 1023, watchdog limit in cycles; only used with AXI_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  STRB_W  write byte strobes.
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  completion carried SLVERR/DECERR or timeout.
- axi_error  out  1  sticky error flag.
- AXI4-Lite master channels: axi_awaddr/awvalid/awready/awprot, axi_wdata/wstrb/wvalid/wready, axi_bresp/bvalid/bready, axi_araddr/arvalid/arready/arprot, axi_rdata/rresp/rvalid/rready; widths ADDR_W, DATA_W, STRB_W, resp 2, prot 3.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE, HUNG.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/wstrb/we; we=0 -> RD_ADDR, we=1 -> WR_REQ.
- RD_ADDR: arvalid=1 from registers; on arready -> RD_DATA.
- RD_DATA: rready=1; on rvalid latch rdata (or 0 if rresp[1]) and err=rresp[1] -> DONE.
- WR_REQ: awvalid and wvalid asserted together, each dropped independently on its own ready (tracked by aw_done/w_done flags). When both done, including the same cycle -> WR_RESP.
- WR_RESP: bready=1; on bvalid err=bresp[1] -> DONE.
- DONE: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid that cycle; if err, set axi_error. -> IDLE.
- OKAY and EXOKAY both count as success; SLVERR and DECERR set err.
- Only one transaction is ever outstanding. No request is accepted outside IDLE.
- axi_error stays set until reset.
- HUNG is reachable only with AXI_TIMEOUT_EN.

## Timing
- Reset (async assert, sync-safe release): state IDLE; all AXI valid/ready outputs 0; resp_valid 0, resp_rdata 0, resp_err 0, axi_error 0; aw_done/w_done 0; watchdog 0.
- AXI valid signals are registered, never combinational from inputs, and held stable with payload until handshake.
- Best-case read: accept cycle N, arvalid N+1 (arready same cycle), rvalid N+2, resp_valid N+3.
- Best-case write: accept N, aw/w valid N+1, bvalid N+2, resp_valid N+3.
- req_ready is 0 from the cycle after acceptance until the cycle after resp_valid. Back-to-back throughput is 1 transaction per 4 cycles minimum.
- Early bvalid or rvalid is not sampled outside its state, because bready and rready are 0 there.
- Reset mid-transaction drops all valids immediately. The bus is expected to be reset together with the bridge.

## Configuration
- AXI_TIMEOUT_EN defined:
  - A counter clears on entry to any wait state and increments each cycle spent in RD_ADDR, RD_DATA, WR_REQ or WR_RESP.
  - When the counter reaches TIMEOUT, resp_valid pulses with resp_err=1 and resp_rdata=0, and axi_error is set.
  - The FSM then enters HUNG, where req_ready=0 and all AXI outputs are 0, until reset.
  - Any valid still asserted is dropped. This is an accepted protocol violation on a dead bus.
- AXI_TIMEOUT_EN undefined: no counter, no HUNG state; the bridge waits indefinitely.

## Test plan
- Read 0x0000_1000, slave returns arready immediately, rdata=0xDEADBEEF, OKAY -> resp_valid on cycle N+3, resp_rdata=0xDEADBEEF, resp_err=0, axi_error=0.
- Write 0x0000_2004, wdata=0x12345678, wstrb=4'b0011; wready 3 cycles before awready; bresp OKAY -> awaddr/wdata/wstrb stable until each handshake, single resp_valid with resp_err=0.
- Read returning rresp=2'b10 -> resp_err=1, resp_rdata=0, axi_error=1 and stays 1 through a following OKAY read.
- Slave asserts bvalid together with awready/wready, and req_valid is held high continuously -> no response lost, and each request is accepted only in IDLE.
- With AXI_TIMEOUT_EN and TIMEOUT=16, arready held 0 -> resp_valid with resp_err=1 exactly 16 cycles after arvalid rises. After that, req_ready=0 and arvalid=0 permanently until rst_n pulses.
- Assert rst_n=0 while in WR_REQ -> awvalid, wvalid and req_ready go to their reset values asynchronously; after release, a read completes normally.
